// File: rtl/alu_pipe.sv
// alu_pipe: registered valid/ready integer ALU with a 2*WIDTH result and V/C/Z/N flags.
// Define ALU_DIV_EN to compile in the WIDTH-cycle restoring unsigned divider (op 01111).
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [4:0]         ALUControl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               V,
    output logic               C,
    output logic               Z,
    output logic               N
);
    localparam int SHW = $clog2(WIDTH);

    // Handshake: an op transfers on in_valid && in_ready, a result on out_valid && out_ready;
    // the output register holds its contents until the transfer, and may drain and reload in one cycle.
    logic               accept;
    logic               load;
    logic [2*WIDTH-1:0] load_res;
    logic               load_v;
    logic               load_c;

    logic               out_valid_q;
    logic [2*WIDTH-1:0] result_q;
    logic               v_q, c_q, z_q, n_q;

    logic [2*WIDTH-1:0] op_res;
    logic               op_v, op_c;
    logic [WIDTH-1:0]   b_eff;
    logic               cin;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [SHW-1:0]     shamt;

    assign accept = in_valid && in_ready;

    always_comb begin
        op_res = '0;
        op_v   = 1'b0;
        op_c   = 1'b0;
        shamt  = b[SHW-1:0];
        cin    = (ALUControl == 5'b00001);
        b_eff  = cin ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (ALUControl)
            5'b00000, 5'b00001: begin
                op_res[WIDTH:0] = sum;
                op_c = sum[WIDTH];
                op_v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            5'b00010: op_res = prod;
            5'b00011: op_res[WIDTH-1:0] = a & b;
            5'b00100: op_res[WIDTH-1:0] = a | b;
            5'b00101: op_res[WIDTH-1:0] = a ^ b;
            5'b00110: op_res[WIDTH-1:0] = a >> shamt;
            5'b00111: op_res[WIDTH-1:0] = a << shamt;
            5'b01000: op_res[WIDTH-1:0] = $signed(a) >>> shamt;
            5'b01001: op_res[0] = (a == b);
            5'b01010: op_res[0] = (a < b);
            5'b01011: op_res[0] = (a >= b);
            5'b01100: op_res[0] = ($signed(a) < $signed(b));
            5'b01101: op_res[0] = ($signed(a) >= $signed(b));
            5'b01110: op_res[0] = (a != b);
`ifdef ALU_DIV_EN
            // Divide-by-zero completes immediately; non-zero divisors go through the FSM.
            5'b01111: begin
                if (b == '0) begin
                    op_res = {a, {WIDTH{1'b1}}};
                    op_v   = 1'b1;
                end
            end
`endif
            default: op_res = '0;
        endcase
    end

`ifdef ALU_DIV_EN
    typedef enum logic {S_IDLE, S_DIV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             div_start;
    logic             div_done;

    assign div_start = accept && (ALUControl == 5'b01111) && (b != '0);
    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        den_d    = den_q;
        cnt_d    = cnt_q;
        div_done = 1'b0;
        // quo_q shifts the dividend out at the top while quotient bits enter at the bottom.
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, den_q};
        case (state_q)
            S_IDLE: begin
                if (div_start) begin
                    state_d = S_DIV;
                    rem_d   = '0;
                    quo_d   = a;
                    den_d   = b;
                    cnt_d   = '0;
                end
            end
            S_DIV: begin
                if (rem_sh >= {1'b0, den_q}) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d  = S_IDLE;
                    div_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            den_q   <= den_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        if (div_done) begin
            load     = 1'b1;
            load_res = {rem_d, quo_d};
            load_v   = 1'b0;
            load_c   = 1'b0;
        end else begin
            load     = accept && !div_start;
            load_res = op_res;
            load_v   = op_v;
            load_c   = op_c;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        load     = accept;
        load_res = op_res;
        load_v   = op_v;
        load_c   = op_c;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            v_q         <= 1'b0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            result_q    <= load_res;
            v_q         <= load_v;
            c_q         <= load_c;
            z_q         <= (load_res[WIDTH-1:0] == '0);
            n_q         <= load_res[WIDTH-1];
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign V         = v_q;
    assign C         = c_q;
    assign Z         = z_q;
    assign N         = n_q;
endmodule
